// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one host memory channel between the
// scratchpad ports of an HLS kernel; one host transaction in flight at a time.
module mem_port_arbiter #(
    parameter int ADDR_WID = 14,
    parameter int DATA_WID = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         read_base,
    input  logic [63:0]         write_base,
    input  logic [63:0]         size_input,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDR_WID-1:0] addr0,
    input  logic [ADDR_WID-1:0] addr1,
    input  logic [DATA_WID-1:0] d0,
    input  logic [DATA_WID-1:0] d1,
    output logic [DATA_WID-1:0] q0,
    output logic [DATA_WID-1:0] q1,
    output logic                ack0,
    output logic                ack1,
    output logic                read_enable,
    output logic [63:0]         read_addr,
    output logic [63:0]         read_size_output,
    input  logic                read_ready,
    input  logic [31:0]         read_data,
    output logic                write_enable,
    output logic [63:0]         write_addr,
    output logic [63:0]         write_size,
    output logic [31:0]         write_data,
    input  logic                write_ready,
    output logic                busy,
    output logic [63:0]         access_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic                last;
    logic                gnt;
    logic                sel;
    logic                sel_we;
    logic [ADDR_WID-1:0] sel_addr;
    logic [DATA_WID-1:0] sel_d;
    logic [63:0]         sel_offset;
    logic                issue;
    logic                complete;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        sel        = (req0 && req1) ? ~last : req1;
        sel_we     = sel ? we1 : we0;
        sel_addr   = sel ? addr1 : addr0;
        sel_d      = sel ? d1 : d0;
        sel_offset = {{(64 - ADDR_WID){1'b0}}, sel_addr} << 2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is only honoured once the one-cycle enable pulse has dropped.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    issue      = 1'b1;
                    state_next = sel_we ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (!read_enable && read_ready) begin
                    complete   = 1'b1;
                    state_next = ACK;
                end
            end
            WAIT_WR: begin
                if (!write_enable && write_ready) begin
                    complete   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last             <= 1'b1;
            gnt              <= 1'b0;
            read_enable      <= 1'b0;
            write_enable     <= 1'b0;
            read_addr        <= '0;
            read_size_output <= '0;
            write_addr       <= '0;
            write_size       <= '0;
            write_data       <= '0;
        end else begin
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            if (issue) begin
                gnt  <= sel;
                last <= sel;
                if (sel_we) begin
                    write_addr   <= write_base + sel_offset;
                    write_size   <= size_input;
                    write_data   <= sel_d;
                    write_enable <= 1'b1;
                end else begin
                    read_addr        <= read_base + sel_offset;
                    read_size_output <= size_input;
                    read_enable      <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            q0         <= '0;
            q1         <= '0;
            access_cnt <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (complete) begin
                access_cnt <= access_cnt + 64'd1;
                if (gnt) begin
                    ack1 <= 1'b1;
                end else begin
                    ack0 <= 1'b1;
                end
                if (state == WAIT_RD) begin
                    if (gnt) begin
                        q1 <= read_data;
                    end else begin
                        q0 <= read_data;
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [63:0] read_base, write_base, size_input;
    logic        req0, req1, we0, we1;
    logic [13:0] addr0, addr1;
    logic [31:0] d0, d1;
    logic [31:0] q0, q1;
    logic        ack0, ack1;
    logic        read_enable, write_enable;
    logic [63:0] read_addr, read_size_output, write_addr, write_size;
    logic        read_ready, write_ready;
    logic [31:0] read_data, write_data;
    logic        busy;
    logic [63:0] access_cnt;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_WID(14), .DATA_WID(32)) dut (
        .clk(clk), .reset(reset),
        .read_base(read_base), .write_base(write_base), .size_input(size_input),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .d0(d0), .d1(d1),
        .q0(q0), .q1(q1), .ack0(ack0), .ack1(ack1),
        .read_enable(read_enable), .read_addr(read_addr),
        .read_size_output(read_size_output),
        .read_ready(read_ready), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_size(write_size), .write_data(write_data),
        .write_ready(write_ready), .busy(busy), .access_cnt(access_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one transaction record plus the age in edges since issue.
    logic        m_active, m_ackph, m_we, m_port, m_last, e_ren, e_wen;
    int          m_age;
    logic [63:0] m_raddr, m_rsize, m_waddr, m_wsize, m_cnt;
    logic [31:0] m_wdata, m_q0, m_q1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 0; m_ackph = 0; m_we = 0; m_port = 0; m_last = 1;
        e_ren = 0; e_wen = 0; m_age = 0;
        m_raddr = '0; m_rsize = '0; m_waddr = '0; m_wsize = '0; m_cnt = '0;
        m_wdata = '0; m_q0 = '0; m_q1 = '0;
    endtask

    task automatic model_step();
        logic [13:0] a;
        if (!reset) begin
            model_clear();
            return;
        end
        e_ren = 0;
        e_wen = 0;
        if (m_ackph) begin
            m_ackph = 0;
        end else if (m_active) begin
            m_age++;
            if (m_age >= 2 && (m_we ? write_ready : read_ready)) begin
                m_active = 0;
                m_ackph  = 1;
                m_cnt    = m_cnt + 64'd1;
                if (!m_we) begin
                    if (m_port) m_q1 = read_data;
                    else        m_q0 = read_data;
                end
            end
        end else if (req0 || req1) begin
            m_port   = (req0 && req1) ? !m_last : req1;
            m_last   = m_port;
            m_active = 1;
            m_age    = 0;
            m_we     = m_port ? we1 : we0;
            a        = m_port ? addr1 : addr0;
            if (m_we) begin
                m_waddr = write_base + 64'(a) * 64'd4;
                m_wsize = size_input;
                m_wdata = m_port ? d1 : d0;
                e_wen   = 1;
            end else begin
                m_raddr = read_base + 64'(a) * 64'd4;
                m_rsize = size_input;
                e_ren   = 1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("busy", busy, m_active || m_ackph);
        check_eq("ack0", ack0, m_ackph && !m_port);
        check_eq("ack1", ack1, m_ackph && m_port);
        check_eq("read_enable", read_enable, e_ren);
        check_eq("write_enable", write_enable, e_wen);
        check_eq("read_addr", read_addr, m_raddr);
        check_eq("read_size", read_size_output, m_rsize);
        check_eq("write_addr", write_addr, m_waddr);
        check_eq("write_size", write_size, m_wsize);
        check_eq("write_data", write_data, m_wdata);
        check_eq("q0", q0, m_q0);
        check_eq("q1", q1, m_q1);
        check_eq("access_cnt", access_cnt, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic new_req(input int p);
        if (p == 0) begin
            req0 = 1; we0 = 1'($urandom); addr0 = 14'($urandom); d0 = $urandom;
        end else begin
            req1 = 1; we1 = 1'($urandom); addr1 = 14'($urandom); d1 = $urandom;
        end
    endtask

    task automatic async_reset();
        reset = 0;
        #2;
        model_clear();
        compare_all();
    endtask

    int n_en;
    int ack_order[$];

    initial begin
        reset = 0; read_base = '0; write_base = '0; size_input = '0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
        d0 = '0; d1 = '0; read_ready = 0; write_ready = 0; read_data = '0;
        model_clear();
        #1;
        compare_all();
        tick();
        tick();
        reset = 1;
        tick();

        // Single read on port 0
        req0 = 1; we0 = 0; addr0 = 14'd5; read_base = 64'h1000; size_input = 64'd4;
        tick();
        check_eq("rd_addr_0x1014", read_addr, 64'h1014);
        check_eq("rd_en_pulse", read_enable, 1'b1);
        tick();
        check_eq("rd_en_drop", read_enable, 1'b0);
        read_ready = 1; read_data = 32'hDEADBEEF;
        tick();
        check_eq("ack0_single", ack0, 1'b1);
        check_eq("q0_single", q0, 64'hDEADBEEF);
        check_eq("cnt_single", access_cnt, 64'd1);
        check_eq("q1_untouched", q1, 64'd0);
        req0 = 0; read_ready = 0;
        tick();

        // Single write on port 1 at the top word address
        req1 = 1; we1 = 1; addr1 = 14'h3FFF; d1 = 32'd7; write_base = 64'h2000;
        write_ready = 1;
        tick();
        check_eq("wr_addr_0x11FFC", write_addr, 64'h11FFC);
        check_eq("wr_data_7", write_data, 64'd7);
        write_ready = 0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("no_ack1_before_ready", ack1, 1'b0);
        write_ready = 1;
        tick();
        check_eq("ack1_after_ready", ack1, 1'b1);
        req1 = 0; write_ready = 0;
        tick();

        // Contention with reads always ready
        req0 = 1; we0 = 0; addr0 = 14'd1; req1 = 1; we1 = 0; addr1 = 14'd2;
        read_ready = 1;
        n_en = 0;
        ack_order.delete();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (read_enable || write_enable) n_en++;
            if (ack0) ack_order.push_back(0);
            if (ack1) ack_order.push_back(1);
        end
        req0 = 0; req1 = 0; read_ready = 0;
        check_eq("contention_enables", 64'(n_en), 64'd4);
        check_eq("contention_acks", 64'(ack_order.size()), 64'd4);
        for (int i = 0; i < ack_order.size(); i++)
            check_eq("contention_order", 64'(ack_order[i]), 64'(i % 2));
        tick();

        // Ready stall with stray write_ready pulses
        req0 = 1; we0 = 0; addr0 = 14'd9;
        tick();
        n_en = 0;
        for (int i = 0; i < 50; i++) begin
            write_ready = 1'(i);
            tick();
            if (i > 0 && (read_enable || write_enable)) n_en++;
            if (ack0 || ack1) n_en++;
        end
        write_ready = 0;
        check_eq("stall_no_extra_events", 64'(n_en), 64'd0);
        check_eq("stall_busy", busy, 1'b1);
        read_ready = 1; read_data = 32'h12345678;
        tick();
        check_eq("stall_ack0", ack0, 1'b1);
        req0 = 0; read_ready = 0;
        tick();

        // Reset in WAIT_RD, then a tie after release
        req0 = 1; we0 = 0; addr0 = 14'd3;
        tick();
        tick();
        async_reset();
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_cnt", access_cnt, 64'd0);
        req0 = 0;
        tick();
        tick();
        check_eq("reset_no_ack", ack0 || ack1, 1'b0);
        req0 = 1; we0 = 0; addr0 = 14'd10; req1 = 1; we1 = 0; addr1 = 14'd20;
        read_base = 64'h0; read_ready = 1;
        reset = 1;
        tick();
        check_eq("tie_after_reset_addr", read_addr, 64'd40);
        tick();
        tick();
        check_eq("tie_after_reset_ack0", ack0, 1'b1);
        req0 = 0; req1 = 0; read_ready = 0;
        tick();
        tick();

        // Randomized traffic, including wrap-around bases and occasional resets
        for (int c = 0; c < 3000; c++) begin
            read_ready  = ($urandom_range(0, 2) != 0);
            write_ready = ($urandom_range(0, 2) != 0);
            read_data   = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                read_base  = {$urandom, $urandom};
                write_base = {$urandom, $urandom};
                size_input = {$urandom, $urandom};
            end
            tick();
            if (!reset) begin
                reset = 1;
            end else if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end
            if (req0 && m_ackph && !m_port) begin
                if ($urandom_range(0, 1) != 0) new_req(0); else req0 = 0;
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                new_req(0);
            end
            if (req1 && m_ackph && m_port) begin
                if ($urandom_range(0, 1) != 0) new_req(1); else req1 = 0;
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                new_req(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single host memory channel (read_enable/read_ready, write_enable/write_ready handshake, 32-bit data, byte addressing from 64-bit bases) between the two scratchpad ports (port 0, port 1) of an HLS kernel. The kernel now runs on `clk`, with no gated module clock. The block round-robins between ports and issues one host transaction at a time. It returns read data and a one-cycle acknowledge to the requesting port, and counts completed accesses for the access-amount report.

## Interface
- ADDR_WID, 14, word address width of each port
- DATA_WID, 32, data width
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- read_base  in  64  byte base for reads
- write_base  in  64  byte base for writes
- size_input  in  64  copied to read_size_output/write_size on issue
- req0 / req1  in  1  port request, held high until matching ack
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  ADDR_WID  word address; valid while req high
- d0 / d1  in  DATA_WID  write data; valid while req high
- q0 / q1  out  DATA_WID  last read data for that port, held until next read completes
- ack0 / ack1  out  1  one-cycle completion pulse
- read_enable  out  1  one-cycle read issue pulse
- read_addr  out  64  read byte address
- read_size_output  out  64  read size
- read_ready  in  1  host read data valid
- read_data  in  32  host read data
- write_enable  out  1  one-cycle write issue pulse
- write_addr  out  64  write byte address
- write_size  out  64  write size
- write_data  out  32  write data
- write_ready  in  1  host write complete
- busy  out  1  high in every state except IDLE
- access_cnt  out  64  completed transactions, wraps at 2^64

## Operation
- States:
  - IDLE: samples requests.
  - WAIT_RD / WAIT_WR: a host transaction is in flight.
  - ACK: pulses the acknowledge to the granted port.
- IDLE grant rules:
  - If exactly one req is high, that port is granted.
  - If both are high, the port other than `last` is granted, where `last` is the most recently granted port. `last` resets to 1, so port 0 wins the first tie.
  - If none is high, stay in IDLE.
- Issuing a grant:
  - Latch `gnt`, set `last<=gnt`.
  - If we=0: go to WAIT_RD. read_addr <= read_base + (addr<<2), zero-extended to 64 bits before the shift. read_size_output <= size_input. read_enable <= 1.
  - If we=1: go to WAIT_WR. write_addr <= write_base + (addr<<2). write_size <= size_input. write_data <= d. write_enable <= 1.
- Address addition is 64-bit modulo 2^64; no overflow flag.
- WAIT_RD / WAIT_WR:
  - The enable is forced to 0 on the first edge after issue.
  - ready is ignored while the enable is high.
  - On the first later edge where read_ready (or write_ready) is 1, go to ACK. ack<gnt> <= 1 and access_cnt increments.
  - For reads, q<gnt> <= read_data on that same edge.
  - With ready never asserted, the block waits indefinitely; there is no timeout.
- ACK: ack drops to 0 and the state returns to IDLE. The requester may keep req high to present a new request; it is sampled in IDLE on the next edge.
- read_ready and write_ready are ignored outside their matching WAIT state. The q of the non-granted port never changes.
- Asynchronous reset while low:
  - state=IDLE, last=1.
  - Enables, acks, busy = 0.
  - All address/size/data outputs, q0, q1 and access_cnt = 0.
  - Any in-flight transaction is abandoned, with no ack.

## Timing
- Edge E0 (IDLE, req high): the enable is high and the address is valid for the cycle after E0.
- Edge E1: the enable returns to 0.
- Earliest ready sampled at E2. Ack is high for the cycle after E2, and q is valid from the same cycle.
- Minimum request-to-ack latency: 3 edges. Minimum back-to-back spacing per transaction: 4 cycles.
- busy rises with the enable and falls when ack falls.
- Exactly one enable pulse per transaction. read_enable and write_enable are never high together.
- Exactly one ack pulse per transaction, and only for the granted port.

## Test plan
- Single read: reset released, req0=1, we0=0, addr0=5, read_base=0x1000, read_ready=1 two cycles after the enable, read_data=0xDEADBEEF.
  - Expect read_addr=0x1014 with a one-cycle read_enable.
  - Expect ack0 pulse with q0=0xDEADBEEF, access_cnt=1, q1 unchanged at 0.
- Single write: req1=1, we1=1, addr1=0x3FFF, d1=7, write_base=0x2000.
  - Expect write_addr=0x11FFC, write_data=7, one write_enable pulse.
  - Expect ack1 only after write_ready.
- Contention: req0 and req1 both held high with reads continuously ready.
  - Expect grants 0,1,0,1 and acks alternating.
  - Expect exactly 4 enable pulses for 4 transactions.
- Ready stall: hold read_ready=0 for 50 cycles after issue, also pulsing write_ready during the wait.
  - Expect busy held high, no ack, no extra enable.
  - Expect completion only on read_ready.
- Reset mid-operation: drive reset low while in WAIT_RD.
  - Expect immediate (asynchronous) zero on all outputs and no ack.
  - After release, req1 and req0 together are expected to grant port 0 first.
